// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and types.
// Optional build macro: FETCH_PERF_EN (adds performance counters to fetch_unit).
package fetch_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned RESET_PC = 0;
  localparam int unsigned PC_STEP  = 1;

  // Bubble-fill instruction for decode and benches.
  localparam logic [31:0] NOP_INSTR = 32'hA800_0000;

  // Per-cycle action of the fetch datapath, listed in priority order.
  typedef enum logic [1:0] {
    FETCH_REDIRECT,
    FETCH_STALL,
    FETCH_ADVANCE
  } fetch_act_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch-stage event counters (fetched, stalled, squashed), 32-bit wrapping.
// Instantiated by fetch_unit only when FETCH_PERF_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire_i,
  input  logic        stall_i,
  input  logic        squash_i,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stalls_o,
  output logic [31:0] perf_squashed_o
);

  logic [31:0] fetched_q, stalls_q, squashed_q;

  // Count each event class once per cycle it occurs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q  <= '0;
      stalls_q   <= '0;
      squashed_q <= '0;
    end else begin
      if (fire_i)   fetched_q  <= fetched_q + 32'd1;
      if (stall_i)  stalls_q   <= stalls_q + 32'd1;
      if (squash_i) squashed_q <= squashed_q + 32'd1;
    end
  end

  assign perf_fetched_o  = fetched_q;
  assign perf_stalls_o   = stalls_q;
  assign perf_squashed_o = squashed_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, and presents (pc, instr) to decode over valid/ready. Branch
// redirects squash the presented instruction and restart fetch.
// Optional build macro: FETCH_PERF_EN (adds perf_fetched/perf_stalls/perf_squashed).
module fetch_unit #(
  parameter int unsigned       ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned       INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(fetch_pkg::PC_STEP)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls,
  output logic [31:0]        perf_squashed
`endif
);

  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              stall;
  fetch_act_e        act;

  // Redirect squashes the presented instruction combinationally.
  assign id_valid = rsp_valid_q & ~redirect_valid;
  assign id_pc    = rsp_pc_q;
  assign id_instr = imem_instr;
  assign stall    = id_valid & ~id_ready;

  // While stalled, re-issue the presented address so memory keeps its word stable.
  assign imem_addr = stall ? rsp_pc_q : pc_q;

  // Select the cycle action by priority, then form next state.
  always_comb begin
    act         = FETCH_ADVANCE;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rsp_valid_q;
    if (redirect_valid) begin
      act = FETCH_REDIRECT;
    end else if (stall) begin
      act = FETCH_STALL;
    end
    unique case (act)
      FETCH_REDIRECT: begin
        pc_d        = redirect_pc;
        rsp_valid_d = 1'b0;
      end
      FETCH_STALL: ;
      FETCH_ADVANCE: begin
        rsp_pc_d    = pc_q;
        rsp_valid_d = 1'b1;
        pc_d        = pc_q + PC_STEP;
      end
      default: ;
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk            (clk),
    .rst            (rst),
    .fire_i         (id_valid & id_ready),
    .stall_i        (stall),
    .squash_i       (redirect_valid & rsp_valid_q),
    .perf_fetched_o (perf_fetched),
    .perf_stalls_o  (perf_stalls),
    .perf_squashed_o(perf_squashed)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, instr) pairs are queued as
// stimulus is planned and popped whenever decode accepts an instruction.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr = '0;
  logic          id_valid;
  logic          id_ready = 1'b1;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_stalls, perf_squashed;
`endif

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stalls   (perf_stalls),
    .perf_squashed (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: registered read, decodes low 8 address bits.
  logic [IW-1:0] mem [0:255];
  always @(posedge clk) imem_instr <= mem[imem_addr[7:0]];

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned exp_fetched = 0;
  int unsigned exp_stalls = 0;
  int unsigned exp_squashed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem[pc[7:0]];
    sb.push_back(e);
  endtask

  task automatic perf_check();
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, exp_fetched);
    check("perf_stalls", perf_stalls, exp_stalls);
    check("perf_squashed", perf_squashed, exp_squashed);
`endif
  endtask

  // One clock cycle: drive inputs after the edge, check id_valid mid-cycle.
  // pres = an instruction is expected to be held in the response register.
  task automatic cyc(input logic ready, input logic rv, input logic [AW-1:0] rpc,
                     input logic pres);
    @(posedge clk);
    #1;
    perf_check();
    id_ready       = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    check("id_valid", id_valid, pres & ~rv);
    if (pres & ~rv & ready)  exp_fetched++;
    if (pres & ~rv & ~ready) exp_stalls++;
    if (pres & rv)           exp_squashed++;
  endtask

  // Scoreboard consumer: every accepted instruction must match the queue head.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_instr", id_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h2200_0005;
    mem[1] = 32'h2440_0003;
    mem[2] = NOP_INSTR;
    mem[3] = 32'hA000_FFFD;

    repeat (2) @(posedge clk);
    #1;
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_imem_addr", imem_addr, 32'd0);

    // Release reset; first cycle is still a bubble.
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("c0_id_valid", id_valid, 1'b0);
    check("c0_id_pc", id_pc, 32'd0);
    check("c0_imem_addr", imem_addr, 32'd0);

    // Streaming, no gaps.
    for (int p = 0; p < 4; p++) push(AW'(p));
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, '0, 1'b1);

    // Redirect to 1 (pc 4 squashed), bubble, then stall on pc 1.
    cyc(1'b1, 1'b1, 32'd1, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    check("redir_bubble_addr", imem_addr, 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, '0, 1'b1);
      check("stall_pc", id_pc, 32'd1);
      check("stall_instr", id_instr, 32'h2440_0003);
      check("stall_addr", imem_addr, 32'd1);
    end
    push(32'd1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    push(32'd2);
    cyc(1'b1, 1'b0, '0, 1'b1);
    check("resume_pc", id_pc, 32'd2);

    // Redirect to 0 while pc 3 is presented.
    cyc(1'b1, 1'b1, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    push(32'd0);
    cyc(1'b1, 1'b0, '0, 1'b1);

    // Redirect during stall: redirect wins.
    cyc(1'b0, 1'b1, 32'd2, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    check("rds_bubble_addr", imem_addr, 32'd2);
    push(32'd2);
    cyc(1'b1, 1'b0, '0, 1'b1);
    push(32'd3);
    cyc(1'b1, 1'b0, '0, 1'b1);

    // Asynchronous reset between edges.
    @(posedge clk);
    #1;
    perf_check();
    rst = 1'b1;
    #1;
    check("async_id_valid", id_valid, 1'b0);
    check("async_imem_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    exp_fetched  = 0;
    exp_stalls   = 0;
    exp_squashed = 0;
    @(negedge clk);
    check("rel_id_valid", id_valid, 1'b0);
    check("rel_id_pc", id_pc, 32'd0);
    perf_check();
    push(32'd0);
    cyc(1'b1, 1'b0, '0, 1'b1);

    // Wrap: redirect to the last address, then fall through to 0.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0);
    check("wrap_bubble_addr", imem_addr, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF);
    push(32'd0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("wrap_stall_pc", id_pc, 32'd1);
    push(32'd1);
    cyc(1'b1, 1'b0, '0, 1'b1);

    @(posedge clk);
    #1;
    perf_check();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter and drives the word address into instruction memory, which has a registered read with 1-cycle latency.
- Pairs each returned instruction with its PC and hands it to decode over a valid/ready handshake.
- Accepts branch redirects from execute, which squash in-flight fetches.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset (word index).
- PC_STEP, 1, PC increment per instruction (memory is word-indexed).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  address to instruction memory, sampled by memory at posedge.
- imem_instr  in  INSTR_W  memory output; holds the word for the address sampled at the previous edge.
- id_valid  out  1  id_instr/id_pc are valid.
- id_ready  in  1  decode accepts this cycle.
- id_instr  out  INSTR_W  instruction to decode (equals imem_instr).
- id_pc  out  ADDR_W  address of id_instr.
- redirect_valid  in  1  execute resolved a taken branch.
- redirect_pc  in  ADDR_W  branch target (word index).

Behaviour:
- Interface: one clock, clk; reset rst, asynchronous and active-high.
- State registers: pc_q (next address to issue), rsp_pc_q (address whose data is on imem_instr), rsp_valid_q.
- Reset values: pc_q=RESET_PC, rsp_pc_q=0, rsp_valid_q=0. Hence id_valid=0, id_pc=0, imem_addr=RESET_PC.
- Asserting rst mid-operation drops id_valid asynchronously and discards all state.
- Outputs:
  - id_valid = rsp_valid_q & ~redirect_valid.
  - id_pc = rsp_pc_q.
  - id_instr = imem_instr.
- stall = id_valid & ~id_ready.
- imem_addr is combinational: stall ? rsp_pc_q : pc_q.
  - Replaying rsp_pc_q keeps imem_instr stable across stall cycles. No extra hold buffer.
- Next-state, priority order:
  1. redirect_valid: pc_q<=redirect_pc, rsp_valid_q<=0, rsp_pc_q unchanged.
     - Overrides stall.
     - The instruction presented that cycle is younger than the branch and is squashed (id_valid forced 0).
  2. stall: pc_q, rsp_pc_q and rsp_valid_q all hold.
  3. otherwise (advance): rsp_pc_q<=pc_q, rsp_valid_q<=1, pc_q<=pc_q+PC_STEP.
- Latency:
  - First id_valid is 1 cycle after rst deasserts, with id_pc=RESET_PC.
  - Redirect penalty: redirect cycle R (bubble), R+1 (bubble, imem_addr=redirect_pc), R+2 (id_valid=1, id_pc=redirect_pc).
- Throughput: 1 instruction/cycle while id_ready=1.
- Handshake: once asserted, id_valid/id_instr/id_pc stay stable until accepted or squashed by redirect.
- Arithmetic: PC addition is modulo 2^ADDR_W; 0xFFFFFFFF wraps to 0. Memory decodes only the low 8 bits, so fetch wraps at 256 words.
- Consecutive redirects: the last one wins; each resets the bubble sequence.
- A redirect while rsp_valid_q=0 is legal and behaves identically.
- id_ready while id_valid=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched, perf_stalls, perf_squashed (32 bits each, wrapping, reset 0).
  - perf_fetched: +1 per id_valid&id_ready.
  - perf_stalls: +1 per stall cycle.
  - perf_squashed: +1 per redirect cycle with rsp_valid_q=1.
- Undefined: ports and counters absent; fetch behaviour identical.

Decomposition:
- fetch_pkg holds ADDR_W, INSTR_W, RESET_PC, PC_STEP and NOP_INSTR=32'hA8000000 (used by benches and decode for bubble fill).
- Sub-module fetch_perf_ctr holds the three counters and is instantiated only under FETCH_PERF_EN. All other logic stays flat.

Test Plan:
- Streaming: memory preloaded with [0]=22000005, [1]=24400003, [2]=A8000000, [3]=A000FFFD; release rst, id_ready=1 -> cycles 1..4 give (pc,instr) = (0,22000005), (1,24400003), (2,A8000000), (3,A000FFFD) with no gaps.
- Stall: id_ready=0 for 3 cycles while presenting pc=1 -> id_pc=1 and id_instr=24400003 stay stable; imem_addr=1 throughout; resume gives pc=2 next cycle.
- Redirect: redirect_valid=1 with redirect_pc=0 while pc=3 is presented -> id_valid=0 that cycle and the next; then pc=0, 22000005.
- Redirect during stall: id_ready=0 plus redirect_pc=2 -> redirect wins; after 2 bubbles id_pc=2.
- Async reset mid-stream: assert rst between edges -> id_valid=0 immediately; after release, first fetch is pc=0. Wrap: redirect_pc=FFFFFFFF -> next id_pc=0 following FFFFFFFF.
- FETCH_PERF_EN: run the redirect-during-stall scenario -> perf_stalls, perf_squashed and perf_fetched match scoreboard counts exactly.
